// File: rtl/opti_coef_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : opti_coef_loader_pkg
//  Description : Shared constants for the SOS coefficient loader: coefficient
//                width, Q2.14 unity, coefficient index map, per-section word
//                layout, loader FSM state encodings and a write-legality helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package opti_coef_loader_pkg;

  localparam int COEF_W   = 16;
  localparam int NUM_COEF = 5;
  localparam int SEC_BITS = NUM_COEF * COEF_W;  // {a2,a1,b2,b1,b0}

  localparam logic [COEF_W-1:0] Q2_14_ONE = 16'h4000;

  // Coefficient index map; the index is also the 16-bit lane in SEC_BITS.
  localparam logic [2:0] IDX_B0 = 3'd0;
  localparam logic [2:0] IDX_B1 = 3'd1;
  localparam logic [2:0] IDX_B2 = 3'd2;
  localparam logic [2:0] IDX_A1 = 3'd3;
  localparam logic [2:0] IDX_A2 = 3'd4;

  // Unity gain, no feedback: the section passes samples through unchanged.
  localparam logic [SEC_BITS-1:0] PASS_THRU = {{(SEC_BITS-COEF_W){1'b0}}, Q2_14_ONE};

  // Loader FSM encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SWAP  = 2'd2;

  function automatic logic idx_legal(input logic [2:0] idx);
    return (idx <= IDX_A2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/opti_coef_bank.sv
`default_nettype none
// ============================================================================
//  Module      : opti_coef_bank
//  Description : One SOS section's coefficient storage: a shadow register set
//                written one coefficient at a time, and an active register set
//                loaded from the shadow as a whole on swap.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                we_i, idx_i, data_i - shadow write strobe, index, Q2.14 value
//                swap_i            - copy shadow into active this cycle
//                active_o          - active word {a2,a1,b2,b1,b0}
//  Revision    : 1.0 - initial release
// ============================================================================
module opti_coef_bank
  import opti_coef_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [2:0]          idx_i,
  input  logic [COEF_W-1:0]   data_i,
  input  logic                swap_i,
  output logic [SEC_BITS-1:0] active_o
);

  logic [SEC_BITS-1:0] shadow_q;
  logic [SEC_BITS-1:0] shadow_d;
  logic [SEC_BITS-1:0] active_q;

  // Illegal indices never reach here with we_i set; the default arm is a
  // safety net that keeps the shadow untouched.
  always_comb begin
    shadow_d = shadow_q;
    if (we_i) begin
      case (idx_i)
        IDX_B0:  shadow_d[0*COEF_W +: COEF_W] = data_i;
        IDX_B1:  shadow_d[1*COEF_W +: COEF_W] = data_i;
        IDX_B2:  shadow_d[2*COEF_W +: COEF_W] = data_i;
        IDX_A1:  shadow_d[3*COEF_W +: COEF_W] = data_i;
        IDX_A2:  shadow_d[4*COEF_W +: COEF_W] = data_i;
        default: shadow_d = shadow_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= PASS_THRU;
      active_q <= PASS_THRU;
    end else begin
      shadow_q <= shadow_d;
      if (swap_i) begin
        active_q <= shadow_q;
      end
    end
  end

  assign active_o = active_q;

endmodule
`default_nettype wire

// File: rtl/opti_coef_loader.sv
`default_nettype none
// ============================================================================
//  Module      : opti_coef_loader
//  Description : Coefficient writer for a cascaded Q2.14 SOS filter chain.
//                Host writes land in per-section shadow banks; a commit stops
//                new samples, waits for the chain to empty, then swaps every
//                section's shadow into its active bank in one cycle, so no
//                sample ever sees a mixed coefficient set.
//  Ports       : clk, rst                          - clock, sync reset
//                wr_valid/ready/sec/idx/data, wr_err - coefficient write port
//                commit_req/busy/done              - commit handshake
//                src_valid/ready/data              - sample source side
//                sos_valid_in, sos_data_in         - to first SOS section
//                sos_valid_out                     - from last SOS section
//                coef_active                       - active coefficients
//                cnt_err                           - sticky in-flight error
//  Revision    : 1.0 - initial release
// ============================================================================
module opti_coef_loader
  import opti_coef_loader_pkg::*;
#(
  parameter int N_SOS = 2,
  parameter int SEC_W = 1,
  parameter int CNT_W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [SEC_W-1:0]          wr_sec,
  input  logic [2:0]                wr_idx,
  input  logic [COEF_W-1:0]         wr_data,
  output logic                      wr_err,
  input  logic                      commit_req,
  output logic                      commit_busy,
  output logic                      commit_done,
  input  logic                      src_valid,
  output logic                      src_ready,
  input  logic [COEF_W-1:0]         src_data,
  output logic                      sos_valid_in,
  output logic [COEF_W-1:0]         sos_data_in,
  input  logic                      sos_valid_out,
  output logic [N_SOS*SEC_BITS-1:0] coef_active,
  output logic                      cnt_err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] in_flight_q, in_flight_d;
  logic             cnt_err_q, cnt_err_d;
  logic             wr_err_q;
  logic             commit_done_q;

  logic idle;
  logic wr_fire;
  logic sec_ok;
  logic wr_legal;
  logic swap;

  // --------------------------------------------------------------------------
  // Handshakes and sample gating. Sample path is purely combinational so the
  // loader adds no latency in front of section 0.
  // --------------------------------------------------------------------------
  assign idle         = (state_q == ST_IDLE);
  assign wr_ready     = idle;
  assign src_ready    = idle;
  assign sos_valid_in = src_valid & src_ready;
  assign sos_data_in  = src_data;
  assign commit_busy  = ~idle;
  assign commit_done  = commit_done_q;
  assign wr_err       = wr_err_q;
  assign cnt_err      = cnt_err_q;
  assign swap         = (state_q == ST_SWAP);

  // Widened by one bit so the compare stays meaningful when 2**SEC_W == N_SOS.
  assign sec_ok   = ({1'b0, wr_sec} < (SEC_W+1)'(N_SOS));
  assign wr_fire  = wr_valid & wr_ready;
  assign wr_legal = sec_ok & idx_legal(wr_idx);

  // --------------------------------------------------------------------------
  // In-flight counter: samples entered minus samples leaving the last section.
  // Saturates at both ends and flags the event stickily instead of wrapping,
  // which would otherwise let a commit swap under live samples.
  // --------------------------------------------------------------------------
  always_comb begin
    in_flight_d = in_flight_q;
    cnt_err_d   = cnt_err_q;
    case ({sos_valid_in, sos_valid_out})
      2'b10: begin
        if (in_flight_q == CNT_MAX) begin
          cnt_err_d = 1'b1;
        end else begin
          in_flight_d = in_flight_q + CNT_ONE;
        end
      end
      2'b01: begin
        if (in_flight_q == CNT_ZERO) begin
          cnt_err_d = 1'b1;
        end else begin
          in_flight_d = in_flight_q - CNT_ONE;
        end
      end
      default: in_flight_d = in_flight_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Commit FSM. DRAIN blocks samples and writes until the chain is empty;
  // SWAP lasts exactly one cycle and is the only time active banks load.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (commit_req) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (in_flight_q == CNT_ZERO) begin
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      in_flight_q   <= CNT_ZERO;
      cnt_err_q     <= 1'b0;
      wr_err_q      <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_flight_q   <= in_flight_d;
      cnt_err_q     <= cnt_err_d;
      wr_err_q      <= wr_fire & ~wr_legal;
      commit_done_q <= swap;
    end
  end

  // --------------------------------------------------------------------------
  // Per-section coefficient banks; section 0 occupies the LSBs.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < N_SOS; g++) begin : g_bank
    logic bank_we;
    assign bank_we = wr_fire & wr_legal & (wr_sec == SEC_W'(g));

    opti_coef_bank u_bank (
      .clk      (clk),
      .rst      (rst),
      .we_i     (bank_we),
      .idx_i    (wr_idx),
      .data_i   (wr_data),
      .swap_i   (swap),
      .active_o (coef_active[g*SEC_BITS +: SEC_BITS])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_opti_coef_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_opti_coef_loader
//  Description : Self-checking bench for opti_coef_loader. A shift register
//                stands in for the SOS chain latency; expected samples and
//                expected active banks are queued at stimulus time and
//                compared when the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_opti_coef_loader;

  localparam int N_SOS = 3;
  localparam int SEC_W = 2;
  localparam int CNT_W = 6;
  localparam int L     = 8;              // modelled chain latency in cycles
  localparam int W     = N_SOS * 80;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_valid;
  logic             wr_ready;
  logic [SEC_W-1:0] wr_sec;
  logic [2:0]       wr_idx;
  logic [15:0]      wr_data;
  logic             wr_err;
  logic             commit_req;
  logic             commit_busy;
  logic             commit_done;
  logic             src_valid;
  logic             src_ready;
  logic [15:0]      src_data;
  logic             sos_valid_in;
  logic [15:0]      sos_data_in;
  logic             sos_valid_out;
  logic [W-1:0]     coef_active;
  logic             cnt_err;

  logic             auto_chain;
  logic             vo;
  logic [L-1:0]     pipe;

  logic [15:0]      m_sh [N_SOS][5];
  logic [W-1:0]     m_act;
  logic [15:0]      q_samp[$];
  logic [W-1:0]     q_coef[$];

  int n_vec = 0;
  int n_mis = 0;
  int lat;

  always #5 clk = ~clk;

  opti_coef_loader #(.N_SOS(N_SOS), .SEC_W(SEC_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_sec        (wr_sec),
    .wr_idx        (wr_idx),
    .wr_data       (wr_data),
    .wr_err        (wr_err),
    .commit_req    (commit_req),
    .commit_busy   (commit_busy),
    .commit_done   (commit_done),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_data      (src_data),
    .sos_valid_in  (sos_valid_in),
    .sos_data_in   (sos_data_in),
    .sos_valid_out (sos_valid_out),
    .coef_active   (coef_active),
    .cnt_err       (cnt_err)
  );

  // Stand-in for the SOS chain: every accepted sample leaves L cycles later.
  always @(posedge clk) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[L-2:0], sos_valid_in};
  end
  assign sos_valid_out = (auto_chain & pipe[L-1]) | vo;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_model();
    logic [W-1:0] v;
    v = '0;
    for (int s = 0; s < N_SOS; s++)
      for (int i = 0; i < 5; i++)
        v[s*80 + i*16 +: 16] = m_sh[s][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < N_SOS; s++)
      for (int i = 0; i < 5; i++)
        m_sh[s][i] = (i == 0) ? 16'h4000 : 16'h0000;
    m_act = pack_model();
  endtask

  // Scoreboard side: samples reaching section 0 and banks on commit_done.
  always @(negedge clk) begin
    if (!rst) begin
      if (sos_valid_in) begin
        if (q_samp.size() == 0) chk("spurious_sample", 1, 0);
        else                    chk("sample_data", W'(sos_data_in), W'(q_samp.pop_front()));
      end
      if (commit_done) begin
        if (q_coef.size() == 0) chk("spurious_done", 1, 0);
        else                    chk("coef_on_done", coef_active, q_coef.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 two cycles after the write.
  task automatic do_wr(input int sec, input int idx, input logic [15:0] d);
    logic legal;
    legal    = (idx < 5) && (sec < N_SOS);
    wr_valid = 1'b1;
    wr_sec   = SEC_W'(sec);
    wr_idx   = 3'(idx);
    wr_data  = d;
    @(negedge clk);
    chk("wr_ready", W'(wr_ready), 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    if (legal) m_sh[sec][idx] = d;
    @(negedge clk);
    chk("wr_err_pulse", W'(wr_err), W'(!legal));
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_err_once", W'(wr_err), 0);
    @(posedge clk); #1;
  endtask

  // Raises commit_req for one cycle and reports cycles from req to done.
  task automatic do_commit(output int l);
    q_coef.push_back(pack_model());
    commit_req = 1'b1;
    l = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (commit_done) begin
        l = n;
        break;
      end
      @(posedge clk); #1;
      commit_req = 1'b0;
    end
    commit_req = 1'b0;
    m_act = pack_model();
    @(posedge clk); #1;
  endtask

  initial begin
    int done_c;
    rst = 1'b1; wr_valid = 0; wr_sec = '0; wr_idx = '0; wr_data = '0;
    commit_req = 0; src_valid = 0; src_data = '0; vo = 0; auto_chain = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_coef", coef_active, m_act);
    chk("rst_src_ready", W'(src_ready), 1);
    chk("rst_wr_ready", W'(wr_ready), 1);
    chk("rst_busy", W'(commit_busy), 0);
    chk("rst_done", W'(commit_done), 0);
    chk("rst_wr_err", W'(wr_err), 0);
    chk("rst_cnt_err", W'(cnt_err), 0);
    @(posedge clk); #1;

    // Basic commit with an empty chain
    do_wr(0, 0, 16'h2000);
    do_wr(0, 3, 16'hC000);
    chk("active_before_commit", coef_active, m_act);
    do_commit(lat);
    chk("lat_empty", W'(lat), 3);
    chk("sec0_b0", W'(coef_active[15:0]), 16'h2000);
    chk("sec0_a1", W'(coef_active[63:48]), 16'hC000);

    // Illegal writes drop silently apart from wr_err; legal writes accumulate
    do_wr(0, 6, 16'h7777);
    do_wr(N_SOS, 1, 16'h5555);
    do_wr(2, 4, 16'h0ABC);
    do_wr(1, 2, 16'hF00D);
    chk("active_unchanged", coef_active, m_act);
    do_commit(lat);
    chk("lat_empty2", W'(lat), 3);

    // Commit while 4 samples are in flight; the 4th shares the req cycle
    do_wr(1, 0, 16'h1111);
    done_c = -1;
    for (int c = 0; c < 40 && done_c < 0; c++) begin
      src_valid  = (c < 12);
      src_data   = 16'h1000 + 16'(c);
      if (c <= 3) q_samp.push_back(src_data);
      if (c == 3) q_coef.push_back(pack_model());
      commit_req = (c == 3);
      @(negedge clk);
      chk($sformatf("src_ready_c%0d", c), W'(src_ready), W'((c <= 3) || (c >= L + 6)));
      if (commit_done) done_c = c;
      @(posedge clk); #1;
    end
    src_valid = 0; commit_req = 0;
    m_act = pack_model();
    chk("lat_drain", W'(done_c - 3), W'(L + 3));

    // Counter: simultaneous in/out, underflow sticks
    auto_chain = 1'b0;
    for (int c = 0; c < 4; c++) begin
      src_valid = 1'b1;
      src_data  = 16'h2000 + 16'(c);
      q_samp.push_back(src_data);
      vo = (c == 3);
      @(posedge clk); #1;
    end
    src_valid = 0;
    vo = 1'b1;
    repeat (3) @(posedge clk);
    #1 vo = 1'b0;
    @(negedge clk);
    chk("cnt_err_clean", W'(cnt_err), 0);
    @(posedge clk); #1;
    do_commit(lat);
    chk("lat_after_cnt", W'(lat), 3);
    vo = 1'b1;
    @(posedge clk); #1;
    vo = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("cnt_err_sticky", W'(cnt_err), 1);
      @(posedge clk); #1;
    end
    repeat (L) @(posedge clk);
    #1 auto_chain = 1'b1;

    // Reset in DRAIN drops the commit and restores pass-through
    do_wr(1, 1, 16'h1234);
    src_valid = 1'b1; src_data = 16'h3333; q_samp.push_back(src_data);
    commit_req = 1'b1;
    @(posedge clk); #1;
    src_valid = 0; commit_req = 0;
    @(negedge clk);
    chk("drain_busy", W'(commit_busy), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_drain_wr_ready", W'(wr_ready), 1);
    chk("rst_drain_src_ready", W'(src_ready), 1);
    chk("rst_drain_busy", W'(commit_busy), 0);
    chk("rst_drain_coef", coef_active, m_act);
    chk("rst_drain_cnt_err", W'(cnt_err), 0);
    repeat (15) @(posedge clk);
    #1;
    do_commit(lat);
    chk("lat_after_rst", W'(lat), 3);
    chk("shadow_cleared", coef_active, m_act);
    chk("queues_empty", W'(q_samp.size() + q_coef.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
